// File: rtl/pillar_pkg.sv
// Shared types, constants and pattern helpers for the pillar pattern generator.
// Optional gap shrinking is enabled in the top by defining PILLAR_SHRINK_EN.
package pillar_pkg;

  localparam int          ROWS      = 16;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic {
    GAP    = 1'b0,
    PILLAR = 1'b1
  } pgen_state_t;

  // Fold the 4-bit random value into [1, 15-gapH] so rows 0 and 15 stay lit.
  function automatic logic [3:0] gapPos(input logic [3:0] raw, input logic [3:0] gapH);
    logic [3:0] maxPos;
    maxPos = 4'(ROWS - 1) - gapH;
    if (raw == 4'd0)
      gapPos = 4'd1;
    else if (raw > maxPos)
      gapPos = raw - maxPos;
    else
      gapPos = raw;
  endfunction

  function automatic logic [15:0] gapMask(input logic [3:0] pos, input logic [3:0] gapH);
    logic [15:0] m;
    for (int i = 0; i < ROWS; i++)
      m[i] = !((i >= int'(pos)) && (i < int'(pos) + int'(gapH)));
    return m;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit right-shifting Galois LFSR; advances once per asserted step.
module lfsr16
  import pillar_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        step,
  input  logic [15:0] seed,
  output logic [15:0] value
);

  logic [15:0] value_q;

  always_ff @(posedge clk) begin
    if (reset)
      value_q <= seed;
    else if (step)
      value_q <= {1'b0, value_q[15:1]} ^ (value_q[0] ? LFSR_TAPS : 16'h0000);
  end

  assign value = value_q;

endmodule

// File: rtl/pillar_pattern_gen.sv
// Column pattern feeder for the scrolling obstacle matrix: pillars with a random gap.
// Define PILLAR_SHRINK_EN to narrow the gap by one row every fourth pillar (floor 2).
module pillar_pattern_gen
  import pillar_pkg::*;
#(
  parameter int          TICK_DIV = 4,
  parameter int          WIDTH    = 2,
  parameter int          SPACING  = 6,
  parameter int          GAP_H    = 4,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic [15:0] pattern_out,
  output logic        pillar_start,
  output logic [7:0]  pillar_count
);

  pgen_state_t state_q, state_d;
  logic [15:0] colCnt_q, colCnt_d;
  logic [15:0] divCnt_q;
  logic [15:0] pattern_q, pattern_d;
  logic        start_q, start_d;
  logic [7:0]  count_q, count_d;
  logic [15:0] lfsrValue;
  logic [3:0]  gapH;
  logic        tick;
  logic        pillarEvent;
  logic        lfsrUnused;

  assign tick        = (divCnt_q == 16'd0);
  assign pillarEvent = tick && enable && (state_q == GAP) && (colCnt_q == 16'd0);
  assign lfsrUnused  = ^lfsrValue[15:4];

  // The divider free-runs so the scroll cadence never slips while the game is paused.
  always_ff @(posedge clk) begin
    if (reset)
      divCnt_q <= 16'(TICK_DIV - 1);
    else if (tick)
      divCnt_q <= 16'(TICK_DIV - 1);
    else
      divCnt_q <= divCnt_q - 16'd1;
  end

  lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .step  (pillarEvent),
    .seed  (SEED),
    .value (lfsrValue)
  );

`ifdef PILLAR_SHRINK_EN
  logic [3:0] gapH_q;

  // Shrink after the increment that wraps the low two count bits back to zero.
  always_ff @(posedge clk) begin
    if (reset)
      gapH_q <= 4'(GAP_H);
    else if (pillarEvent && (count_q != 8'hFF) && (count_q[1:0] == 2'b11) && (gapH_q > 4'd2))
      gapH_q <= gapH_q - 4'd1;
  end

  assign gapH = gapH_q;
`else
  assign gapH = 4'(GAP_H);
`endif

  always_comb begin
    state_d   = state_q;
    colCnt_d  = colCnt_q;
    pattern_d = pattern_q;
    start_d   = 1'b0;
    count_d   = count_q;
    if (tick && enable) begin
      if (state_q == GAP) begin
        if (colCnt_q != 16'd0) begin
          colCnt_d  = colCnt_q - 16'd1;
          pattern_d = 16'h0000;
        end else begin
          state_d   = PILLAR;
          colCnt_d  = 16'(WIDTH - 1);
          pattern_d = gapMask(gapPos(lfsrValue[3:0], gapH), gapH);
          start_d   = 1'b1;
          if (count_q != 8'hFF)
            count_d = count_q + 8'd1;
        end
      end else begin
        if (colCnt_q != 16'd0) begin
          colCnt_d = colCnt_q - 16'd1;
        end else begin
          state_d   = GAP;
          colCnt_d  = 16'(SPACING - 1);
          pattern_d = 16'h0000;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= GAP;
      colCnt_q  <= 16'(SPACING - 1);
      pattern_q <= 16'h0000;
      start_q   <= 1'b0;
      count_q   <= 8'd0;
    end else begin
      state_q   <= state_d;
      colCnt_q  <= colCnt_d;
      pattern_q <= pattern_d;
      start_q   <= start_d;
      count_q   <= count_d;
    end
  end

  assign pattern_out  = pattern_q;
  assign pillar_start = start_q;
  assign pillar_count = count_q;

endmodule

// File: tb/tb_pillar_pattern_gen.sv
// Self-checking bench for pillar_pattern_gen with default parameters.
// Honours PILLAR_SHRINK_EN when computing expected gap heights.
module tb_pillar_pattern_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] pattern_out;
  logic        pillar_start;
  logic [7:0]  pillar_count;

  always #5 clk = ~clk;

  pillar_pattern_gen dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .pattern_out  (pattern_out),
    .pillar_start (pillar_start),
    .pillar_count (pillar_count)
  );

  typedef struct {
    int          clkIdx;
    logic [15:0] pat;
    logic        st;
    logic [7:0]  cnt;
    string       name;
  } vec_t;

  vec_t vecs[$];
  vec_t expQ[$];
  int   errors = 0;
  int   checks = 0;
  int   now    = 0;

  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      now++;
    end
  endtask

  task automatic pushExpect(input int c, input logic [15:0] p, input logic s,
                            input logic [7:0] k, input string n);
    vec_t v;
    v.clkIdx = c; v.pat = p; v.st = s; v.cnt = k; v.name = n;
    expQ.push_back(v);
  endtask

  task automatic checkOutput();
    vec_t e;
    checks++;
    if (expQ.size() == 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_empty: got nothing queued, want one expectation");
      return;
    end
    e = expQ.pop_front();
    if (pattern_out !== e.pat || pillar_start !== e.st || pillar_count !== e.cnt) begin
      errors++;
      $display("[TB] FAIL %s @clk %0d: got pat=%h start=%b cnt=%0d, want pat=%h start=%b cnt=%0d",
               e.name, now, pattern_out, pillar_start, pillar_count, e.pat, e.st, e.cnt);
    end
  endtask

  task automatic checkValue(input string n, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("[TB] FAIL %s @clk %0d: got %0d, want %0d", n, now, got, want);
    end
  endtask

  function automatic bit patternOk(input logic [15:0] p, input int h);
    int  zeros;
    int  runs;
    logic prev;
    zeros = 0;
    runs  = 0;
    for (int i = 0; i < 16; i++) begin
      prev = (i > 0) ? p[i-1] : 1'b1;
      if (!p[i]) zeros++;
      if (!p[i] && prev) runs++;
    end
    return p[0] && p[15] && (zeros == h) && (runs == 1);
  endfunction

  task automatic doReset();
    reset = 1'b1;
    applyStimulus(2);
    reset = 1'b0;
    now = 0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  waited;
    int  expH;
    int  expCnt;
    bit  sawStart;

    reset  = 1'b1;
    enable = 1'b1;
    doReset();

    vecs.push_back('{0,  16'h0000, 1'b0, 8'd0, "reset_state"});
    vecs.push_back('{4,  16'h0000, 1'b0, 8'd0, "first_tick_blank"});
    vecs.push_back('{23, 16'h0000, 1'b0, 8'd0, "pre_first_pillar"});
    vecs.push_back('{24, 16'hFFE1, 1'b1, 8'd1, "first_pillar"});
    vecs.push_back('{25, 16'hFFE1, 1'b0, 8'd1, "start_pulse_end"});
    vecs.push_back('{31, 16'hFFE1, 1'b0, 8'd1, "pillar_hold"});
    vecs.push_back('{32, 16'h0000, 1'b0, 8'd1, "pillar_off"});
    vecs.push_back('{55, 16'h0000, 1'b0, 8'd1, "pre_second_pillar"});
    vecs.push_back('{56, 16'hFFE1, 1'b1, 8'd2, "second_pillar_clamp"});
    vecs.push_back('{57, 16'hFFE1, 1'b0, 8'd2, "second_pulse_end"});
    vecs.push_back('{88, 16'hF0FF, 1'b1, 8'd3, "third_pillar"});

    foreach (vecs[i]) begin
      pushExpect(vecs[i].clkIdx, vecs[i].pat, vecs[i].st, vecs[i].cnt, vecs[i].name);
      applyStimulus(vecs[i].clkIdx - now);
      checkOutput();
    end

    // Pause for 20 clocks in the middle of pillar 3.
    enable   = 1'b0;
    sawStart = 1'b0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1);
      if (pillar_start) sawStart = 1'b1;
    end
    checkValue("no_start_while_paused", int'(sawStart), 0);
    pushExpect(108, 16'hF0FF, 1'b0, 8'd3, "frozen");
    checkOutput();
    enable = 1'b1;
    applyStimulus(4);
    pushExpect(112, 16'hF0FF, 1'b0, 8'd3, "resume_last_column");
    checkOutput();
    applyStimulus(4);
    pushExpect(116, 16'h0000, 1'b0, 8'd3, "resume_gap");
    checkOutput();
    applyStimulus(24);
    pushExpect(140, 16'hFFE1, 1'b1, 8'd4, "fourth_pillar");
    checkOutput();

    // Reset while the fourth pillar is being emitted.
    reset = 1'b1;
    applyStimulus(1);
    pushExpect(141, 16'h0000, 1'b0, 8'd0, "reset_mid_pillar");
    checkOutput();
    reset = 1'b0;
    now = 0;
    applyStimulus(23);
    pushExpect(23, 16'h0000, 1'b0, 8'd0, "post_reset_blank");
    checkOutput();
    applyStimulus(1);
    pushExpect(24, 16'hFFE1, 1'b1, 8'd1, "post_reset_first");
    checkOutput();

    // Long run: saturation and pattern shape of every pillar.
    for (int n = 2; n <= 300; n++) begin
      applyStimulus(1);
      waited = 0;
      while (!pillar_start && waited < 40) begin
        applyStimulus(1);
        waited++;
      end
      if (!pillar_start) begin
        checkValue("pillar_timeout", 0, 1);
        break;
      end
`ifdef PILLAR_SHRINK_EN
      expH = 4 - (n - 1) / 4;
      if (expH < 2) expH = 2;
`else
      expH = 4;
`endif
      expCnt = (n > 255) ? 255 : n;
      checkValue($sformatf("count_pillar_%0d", n), int'(pillar_count), expCnt);
      checkValue($sformatf("shape_pillar_%0d_pat_%h", n, pattern_out),
                 int'(patternOk(pattern_out, expH)), 1);
    end
    applyStimulus(1);
    checkValue("start_single_cycle", int'(pillar_start), 0);
    checkValue("count_saturated", int'(pillar_count), 255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pillar_pattern_gen.md
Name: pillar_pattern_gen

Overview:
- Upstream feeder for the 16x16 scrolling obstacle chain; it produces the 16-bit column pattern that enters the rightmost matrix column.
- It emits pillar columns (all rows lit except a pseudo-random gap) separated by blank spacing columns.
- Internal tick divider: period TICK_DIV, reload phase chosen so patterns change once per scroll step.
- Also reports pillar-start pulses and a saturating pillar count for scoring.

Parameters:
- TICK_DIV, 4: clocks per scroll step (>=2).
- WIDTH, 2: pillar width in columns (>=1).
- SPACING, 6: blank columns between pillars (>=1).
- GAP_H, 4: gap height in rows, legal 2..7.
- SEED, 16'hACE1: LFSR reset value, nonzero.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  game running; low freezes generation.
- pattern_out  out  16  column pattern; bit i = row i, 1 = lit obstacle.
- pillar_start  out  1  one-cycle pulse on the tick a new pillar's first column is emitted.
- pillar_count  out  8  pillars emitted, saturates at 255.

Behaviour:
- Reset values:
  - pattern_out=0, pillar_start=0, pillar_count=0.
  - state=GAP, col_cnt=SPACING-1, div_cnt=TICK_DIV-1, lfsr=SEED.
- Divider: free-runs regardless of enable. tick=1 when div_cnt==0, which then reloads TICK_DIV-1; otherwise div_cnt decrements. First tick falls TICK_DIV clocks after reset deasserts.
- State advances only on tick&&enable. All outputs are registered and update on that edge.
- GAP state:
  - col_cnt!=0: col_cnt--, pattern_out=0.
  - col_cnt==0: go to PILLAR, col_cnt=WIDTH-1.
    - gap_pos latched from lfsr, lfsr steps once.
    - pattern_out=mask(gap_pos), pillar_start=1, pillar_count+1 (saturating).
- PILLAR state:
  - col_cnt!=0: col_cnt--, hold mask.
  - col_cnt==0: go to GAP, col_cnt=SPACING-1, pattern_out=0.
- mask(p) = 16'hFFFF with rows p..p+GAP_H-1 cleared.
- Gap position, with maxpos = 16-GAP_H-1 and raw = lfsr[3:0]:
  - raw==0 -> p=1.
  - raw>maxpos -> p=raw-maxpos.
  - otherwise p=raw.
  - Result always lies in [1,maxpos], so rows 0 and 15 are always lit.
- LFSR: 16-bit Galois, right shift; if the shifted-out bit is 1, XOR 16'hB400. Never reaches 0.
- pillar_start is high for exactly one clock; 0 on every other cycle.
- enable low: state, col_cnt, lfsr, pattern_out and pillar_count hold; pillar_start=0. On re-enable, resume at the next tick, with no catch-up.
- Reset mid-pillar: everything returns to reset values on the next edge, and the LFSR restarts from SEED, so the sequence is reproducible.
- Period: (WIDTH+SPACING)*TICK_DIV clocks, 32 with defaults.

Optional Feature:
- Macro PILLAR_SHRINK_EN.
- Defined: the effective gap height starts at GAP_H and decreases by 1 after every 4th pillar (when pillar_count[1:0] wraps to 0 on increment), floor 2. maxpos is recomputed from the effective gap height.
- Undefined: gap height is constant GAP_H and no shrink logic is built.

Decomposition:
- Shared package pillar_pkg:
  - ROWS=16.
  - LFSR_TAPS=16'hB400.
  - typedef enum {GAP, PILLAR} pgen_state_t.
  - mask-builder function.
- One sub-module, lfsr16: ports clk, reset, step, seed, value.

Test Plan:
- Reset release with defaults, enable=1: pattern_out=0 through the first 5 ticks. The 6th tick (24 clocks after release) gives pattern_out=16'hFFE1 (seed raw=1 -> rows 1-4 clear), pillar_start=1 for 1 clock, pillar_count=1.
- Continue: 16'hFFE1 is held 8 clocks, then 0. The next pillar appears 32 clocks after the first; the LFSR is now 16'hE270, raw=0 clamps to p=1, giving 16'hFFE1 again, and pillar_count=2.
- Drop enable for 20 clocks mid-pillar: pattern_out, pillar_count and state are unchanged and no pillar_start occurs. After re-enable, the remaining width completes on the next tick.
- Run 300 pillars: pillar_count saturates at 255 with no wrap. Every emitted pattern has bits 0 and 15 set and exactly GAP_H contiguous zeros.
- Assert reset during PILLAR: the next cycle gives pattern_out=0 and pillar_count=0. The first pillar after release is again 16'hFFE1 after 24 clocks.
- With PILLAR_SHRINK_EN: pillars 1-4 have 4 zero rows, pillars 5-8 have 3, pillars 9-12 onward have 2 (held at 2 thereafter).
